// File: rtl/pass_engine.sv
// Index walker for the training passes: steps neuron/input indices of the selected
// pass, drives accumulator clear / MAC / write-back strobes and returns end pulses.
module pass_engine #(
  parameter int L0_N = 4,
  parameter int L0_K = 3,
  parameter int L1_N = 2,
  parameter int L1_K = 4,
  parameter int IW   = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          f0_pass_i,
  input  logic          f1_pass_i,
  input  logic          b_pass_i,
  output logic          acc_clr_o,
  output logic          mac_en_o,
  output logic          wr_en_o,
  output logic          layer_o,
  output logic [IW-1:0] neuron_idx_o,
  output logic [IW-1:0] input_idx_o,
  output logic          busy_o,
  output logic          f0_end_o,
  output logic          f1_end_o,
  output logic          b_end_o
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_WB, S_DONE} state_t;
  typedef enum logic [1:0] {P_F0, P_F1, P_B} pass_t;

  localparam logic [IW-1:0] L0_NL = IW'(L0_N - 1);
  localparam logic [IW-1:0] L0_KL = IW'(L0_K - 1);
  localparam logic [IW-1:0] L1_NL = IW'(L1_N - 1);
  localparam logic [IW-1:0] L1_KL = IW'(L1_K - 1);

  state_t        state_q, state_d;
  pass_t         pass_q, pass_d;
  logic          layer_q, layer_d;
  logic [IW-1:0] nidx_q, nidx_d;
  logic [IW-1:0] iidx_q, iidx_d;
  logic [2:0]    armed_q, armed_d;

  logic [2:0]    req;
  logic          lat_req;
  logic [IW-1:0] n_last, k_last;
  logic          acc_clr, mac_en, wr_en, f0_end, f1_end, b_end;

  assign req    = {b_pass_i, f1_pass_i, f0_pass_i};
  assign n_last = layer_q ? L1_NL : L0_NL;
  assign k_last = layer_q ? L1_KL : L0_KL;

  always_comb begin
    unique case (pass_q)
      P_F0:    lat_req = f0_pass_i;
      P_F1:    lat_req = f1_pass_i;
      P_B:     lat_req = b_pass_i;
      default: lat_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    layer_d = layer_q;
    nidx_d  = nidx_q;
    iidx_d  = iidx_q;
    armed_d = armed_q;
    acc_clr = 1'b0;
    mac_en  = 1'b0;
    wr_en   = 1'b0;
    f0_end  = 1'b0;
    f1_end  = 1'b0;
    b_end   = 1'b0;
    if (en_i) begin
      // A low request level re-arms its pass; completion below clears it again.
      armed_d = armed_q | ~req;
      unique case (state_q)
        S_IDLE: begin
          if (req[0] && armed_q[0]) begin
            pass_d  = P_F0;
            state_d = S_CLR;
            layer_d = 1'b0;
            nidx_d  = '0;
            iidx_d  = '0;
          end else if (req[1] && armed_q[1]) begin
            pass_d  = P_F1;
            state_d = S_CLR;
            layer_d = 1'b1;
            nidx_d  = '0;
            iidx_d  = '0;
          end else if (req[2] && armed_q[2]) begin
            pass_d  = P_B;
            state_d = S_CLR;
            layer_d = 1'b1;
            nidx_d  = '0;
            iidx_d  = '0;
          end
        end
        S_CLR: begin
          acc_clr = 1'b1;
          state_d = lat_req ? S_MAC : S_IDLE;
        end
        S_MAC: begin
          mac_en = 1'b1;
          if (!lat_req) begin
            state_d = S_IDLE;
          end else if (iidx_q == k_last) begin
            state_d = S_WB;
          end else begin
            iidx_d = iidx_q + IW'(1);
          end
        end
        S_WB: begin
          if (!lat_req) begin
            state_d = S_IDLE;
          end else begin
            wr_en = 1'b1;
            if (nidx_q != n_last) begin
              state_d = S_CLR;
              nidx_d  = nidx_q + IW'(1);
              iidx_d  = '0;
            end else if (pass_q == P_B && layer_q) begin
              state_d = S_CLR;
              layer_d = 1'b0;
              nidx_d  = '0;
              iidx_d  = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          unique case (pass_q)
            P_F0: begin f0_end = 1'b1; armed_d[0] = ~req[0]; end
            P_F1: begin f1_end = 1'b1; armed_d[1] = ~req[1]; end
            P_B:  begin b_end  = 1'b1; armed_d[2] = ~req[2]; end
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pass_q  <= P_F0;
      layer_q <= 1'b0;
      nidx_q  <= '0;
      iidx_q  <= '0;
      armed_q <= '1;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      layer_q <= layer_d;
      nidx_q  <= nidx_d;
      iidx_q  <= iidx_d;
      armed_q <= armed_d;
    end
  end

  assign acc_clr_o    = acc_clr;
  assign mac_en_o     = mac_en;
  assign wr_en_o      = wr_en;
  assign f0_end_o     = f0_end;
  assign f1_end_o     = f1_end;
  assign b_end_o      = b_end;
  assign layer_o      = layer_q;
  assign neuron_idx_o = nidx_q;
  assign input_idx_o  = iidx_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: doc/pass_engine.md
# pass_engine

Datapath-side responder to the training pass sequencer. It takes the one-hot pass-select levels (forward pass 0, forward pass 1, backward pass) and walks the neuron and input index space of the selected pass. While it walks, it drives accumulator clear, MAC enable and write-back strobes to the arithmetic datapath. When the pass is done it returns a one-cycle end pulse to the sequencer, which uses it to advance.

## Interface
Parameters:
- L0_N, default 4: neurons in layer 0.
- L0_K, default 3: inputs per layer-0 neuron.
- L1_N, default 2: neurons in layer 1.
- L1_K, default 4: inputs per layer-1 neuron.
- IW, default 3: index width. Must satisfy 2^IW ≥ max(L0_N, L0_K, L1_N, L1_K).

Ports:
- clk_i  in  1  clock. Single clock domain.
- rst_i  in  1  reset. Synchronous, active-high.
- en_i  in  1  global enable. When low, the block stalls.
- f0_pass_i  in  1  forward pass 0 request (level).
- f1_pass_i  in  1  forward pass 1 request (level).
- b_pass_i  in  1  backward pass request (level).
- acc_clr_o  out  1  clear the accumulator.
- mac_en_o  out  1  perform one multiply-accumulate at (layer_o, neuron_idx_o, input_idx_o).
- wr_en_o  out  1  write back the neuron result at (layer_o, neuron_idx_o).
- layer_o  out  1  active layer: 0 or 1.
- neuron_idx_o  out  IW  current neuron index.
- input_idx_o  out  IW  current input index.
- busy_o  out  1  high in any state other than IDLE.
- f0_end_o  out  1  one-cycle pulse: pass 0 complete.
- f1_end_o  out  1  one-cycle pulse: pass 1 complete.
- b_end_o  out  1  one-cycle pulse: backward pass complete.

## Operation
- States:
  - IDLE
  - CLR: acc_clr_o=1, input_idx_o=0.
  - MAC: mac_en_o=1.
  - WB: wr_en_o=1.
  - DONE: the end pulse of the latched pass.
- Strobe and end outputs are decoded from the registered state and gated by en_i.
- Pass latch: in IDLE, the first armed request in priority order f0 > f1 > b is latched.
- Layer plan per pass:
  - f0: layer 0 only.
  - f1: layer 1 only.
  - b: layer 1 first, then layer 0.
- Walk:
  - IDLE → CLR (neuron 0).
  - CLR → MAC, with input_idx_o counting 0..K-1 (K of the active layer).
  - Last MAC → WB.
  - WB → CLR (next neuron) if neuron_idx_o < N-1.
  - Otherwise WB → CLR with layer=0 and neuron 0 if the pass is b and layer_o is 1.
  - Otherwise WB → DONE.
  - DONE → IDLE.
- Re-arm rule:
  - Completing a pass disarms that pass's request.
  - A pass re-arms only after its request level is sampled low.
  - This prevents a re-trigger while the sequencer is still leaving its state.
- Abort: if the latched pass's request goes low in CLR, MAC or WB, the next state is IDLE.
  - No end pulse and no wr_en_o in that cycle.
  - The pass stays armed.
- Indices hold their values in IDLE and DONE. They are 0 after reset.

## Timing
- Reset (rst_i=1 at a clock edge):
  - State = IDLE.
  - All strobes, end pulses and busy_o = 0.
  - layer_o = 0, neuron_idx_o = 0, input_idx_o = 0.
  - All three passes armed.
  - Reset overrides en_i.
- en_i=0:
  - State, counters and arm flags hold.
  - acc_clr_o, mac_en_o, wr_en_o and the end pulses are forced to 0.
  - Index outputs and busy_o remain valid.
- Latency: request sampled in IDLE at edge t. CLR is visible in cycle t+1.
  - Per neuron: K+2 cycles.
  - End pulse appears in cycle t+1+ΣN·(K+2) and lasts exactly one enabled cycle.
  - busy_o drops in the following cycle.
- Default cycle counts (request edge to end pulse):
  - f0: 21 cycles.
  - f1: 13 cycles.
  - b: 33 cycles.
- Simultaneous requests are resolved by priority. The lower-priority requests are neither consumed nor disarmed.
- A request that arrives while busy is ignored until IDLE; it is then served if it is still high and armed.

## Test plan
- Reset, then f0_pass_i=1 held with en_i=1:
  - 4 CLR, 12 MAC and 4 WB strobes.
  - Indices neuron 0..3 and input 0..2, layer_o=0.
  - f0_end_o high exactly in cycle 21.
  - No second pass while f0_pass_i stays high.
- b_pass_i pulse-held:
  - Layer 1: neurons 0..1 with 4 MACs each.
  - Then layer 0: neurons 0..3 with 3 MACs each.
  - b_end_o in cycle 33.
  - Exactly 6 wr_en_o pulses in total.
- f0 run with en_i low for 5 cycles during MAC (neuron 2, input 1):
  - Strobes are 0 during the stall.
  - Indices are frozen.
  - f0_end_o is delayed to cycle 26.
- f1_pass_i dropped mid-MAC:
  - Next cycle is IDLE, with no f1_end_o and no further wr_en_o.
  - Re-asserting f1_pass_i starts a full 13-cycle pass.
- f0_pass_i and b_pass_i asserted together:
  - The f0 pass runs first.
  - f0_pass_i is deasserted after f0_end_o.
  - b is served next, with b_end_o 33 cycles after its IDLE sample.
- rst_i asserted mid-pass (neuron 1 WB):
  - All outputs return to 0 in the next cycle.
  - The pass restarts from neuron 0 once rst_i is released with the request still high.
